inst_ram_dump: RTL and testbench

INST_RAM_DUMP -- requirements
Module: inst_ram_dump

---
 rtl/inst_ram_pkg.sv | 20 ++
 rtl/dump_fifo.sv | 67 ++++++
 rtl/inst_ram_dump.sv | 144 ++++++++++++++
 tb/tb_inst_ram_dump.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_ram_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_ram_pkg : widths and dump-engine state encoding shared by the       |
// |                instruction-RAM read (dump) and write paths.              |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
package inst_ram_pkg;

    localparam int INST_RAM_ADDR_W = 16;
    localparam int INST_RAM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } dump_state_e;

endpackage
`default_nettype wire

// File: rtl/dump_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dump_fifo : two-entry FIFO holding read words tagged with their address. |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module dump_fifo
    import inst_ram_pkg::*;
#(
    parameter int DATA_W = INST_RAM_DATA_W,
    parameter int ADDR_W = INST_RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [1:0]        occupancy_o
);

    logic [DATA_W-1:0] data_q [2];
    logic [ADDR_W-1:0] addr_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q;
    logic              w_do_pop;

    assign full_o      = (occ_q == 2'd2);
    assign empty_o     = (occ_q == 2'd0);
    assign occupancy_o = occ_q;
    assign head_data_o = data_q[rd_ptr_q];
    assign head_addr_o = addr_q[rd_ptr_q];
    assign w_do_pop    = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push_i) begin
                data_q[wr_ptr_q] <= push_data_i;
                addr_q[wr_ptr_q] <= push_addr_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (w_do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push_i} - {1'b0, w_do_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_ram_dump.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_ram_dump : debug-gated streaming dump of instruction RAM contents.  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module inst_ram_dump
    import inst_ram_pkg::*;
#(
    parameter int ADDR_W = INST_RAM_ADDR_W,
    parameter int DATA_W = INST_RAM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              debug,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [ADDR_W-1:0] word_count,
    output logic              inst_ram_read_enable,
    output logic [ADDR_W-1:0] inst_ram_read_address,
    input  logic [DATA_W-1:0] inst_ram_read_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_address,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic              aborted_q, aborted_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] tag_q;

    logic              w_issue;
    logic              w_flush;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [1:0]        w_occ;
    logic [2:0]        w_used;

    assign w_pop  = !w_fifo_empty && dump_ready;
    assign w_push = inflight_q && debug && (!w_fifo_full || w_pop);
    // A word leaving this cycle frees its slot, which keeps the stream at one word per cycle.
    assign w_used = {1'b0, w_occ} + {2'b00, inflight_q} - {2'b00, w_pop};

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        aborted_d   = aborted_q;
        w_issue     = 1'b0;
        w_flush     = 1'b0;
        case (state_q)
            IDLE: begin
                aborted_d = 1'b0;
                if (start && debug) begin
                    addr_d      = start_address;
                    remaining_d = word_count;
                    state_d     = (word_count == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                if (!debug) begin
                    state_d   = FINISH;
                    aborted_d = 1'b1;
                    w_flush   = 1'b1;
                end else if (remaining_q == '0) begin
                    state_d = DRAIN;
                end else if (w_used < 3'd2) begin
                    w_issue     = 1'b1;
                    addr_d      = addr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (!debug) begin
                    state_d   = FINISH;
                    aborted_d = 1'b1;
                    w_flush   = 1'b1;
                end else if (!inflight_q && (w_fifo_empty || (w_occ == 2'd1 && w_pop))) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            aborted_q   <= 1'b0;
            inflight_q  <= 1'b0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            aborted_q   <= aborted_d;
            inflight_q  <= w_issue;
            if (w_issue) begin
                tag_q <= addr_q;
            end
        end
    end

    dump_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dump_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (w_flush),
        .push_i      (w_push),
        .push_data_i (inst_ram_read_data),
        .push_addr_i (tag_q),
        .pop_i       (w_pop),
        .head_data_o (dump_data),
        .head_addr_o (dump_address),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .occupancy_o (w_occ)
    );

    assign dump_valid            = !w_fifo_empty;
    assign inst_ram_read_enable  = w_issue;
    assign inst_ram_read_address = addr_q;
    assign busy                  = (state_q == RUN) || (state_q == DRAIN);
    assign done                  = (state_q == FINISH);
    assign aborted               = (state_q == FINISH) && aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_ram_dump.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_ram_dump : randomized self-checking bench for inst_ram_dump.     |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module tb_inst_ram_dump;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          debug = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_address = '0;
    logic [AW-1:0] word_count = '0;
    logic          inst_ram_read_enable;
    logic [AW-1:0] inst_ram_read_address;
    logic [DW-1:0] inst_ram_read_data;
    logic          dump_valid;
    logic          dump_ready = 1'b0;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_address;
    logic          busy;
    logic          done;
    logic          aborted;

    inst_ram_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .debug                 (debug),
        .start                 (start),
        .start_address         (start_address),
        .word_count            (word_count),
        .inst_ram_read_enable  (inst_ram_read_enable),
        .inst_ram_read_address (inst_ram_read_address),
        .inst_ram_read_data    (inst_ram_read_data),
        .dump_valid            (dump_valid),
        .dump_ready            (dump_ready),
        .dump_data             (dump_data),
        .dump_address          (dump_address),
        .busy                  (busy),
        .done                  (done),
        .aborted               (aborted)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (inst_ram_read_enable) inst_ram_read_data <= mem[inst_ram_read_address];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Consumer ready pattern: 0 always, 1 toggle, 2 random, 3 held low.
    int rdy_mode = 3;
    always @(posedge clk) begin
        #3;
        case (rdy_mode)
            0:       dump_ready = 1'b1;
            1:       dump_ready = ~dump_ready;
            2:       dump_ready = 1'($urandom_range(0, 1));
            default: dump_ready = 1'b0;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [47:0] exp_q [$];
    int          acc_cyc [$];
    int          acc_count = 0;
    int          rd_count = 0;
    int          done_seen = 0;
    logic        stall_pending = 1'b0;
    logic [47:0] held = '0;
    logic [47:0] mon_exp;

    always @(negedge clk) begin
        if (dump_valid && dump_ready) begin
            if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
            else mon_exp = 48'hDEAD_DEAD_DEAD;
            check_eq("word", {dump_address, dump_data}, mon_exp);
            acc_count++;
            acc_cyc.push_back(cyc);
        end
        if (stall_pending) check_eq("head_hold", {dump_valid, dump_address, dump_data}, {1'b1, held});
        stall_pending = dump_valid && !dump_ready && debug && reset;
        held = {dump_address, dump_data};
        if (inst_ram_read_enable) begin
            rd_count++;
            check_eq("read_outside_run", busy, 1);
        end
        if (done) done_seen++;
    end

    task automatic check_zero(input string pfx);
        check_eq({pfx, "_busy"},    busy, 0);
        check_eq({pfx, "_done"},    done, 0);
        check_eq({pfx, "_aborted"}, aborted, 0);
        check_eq({pfx, "_valid"},   dump_valid, 0);
        check_eq({pfx, "_rd_en"},   inst_ram_read_enable, 0);
        check_eq({pfx, "_data"},    dump_data, 0);
        check_eq({pfx, "_daddr"},   dump_address, 0);
        check_eq({pfx, "_rd_addr"}, inst_ram_read_address, 0);
    endtask

    task automatic pulse_start(input logic [AW-1:0] sa, input int cnt);
        @(posedge clk); #1;
        start_address = sa;
        word_count    = AW'(cnt);
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_dump(input logic [AW-1:0] sa, input int cnt, input int mode, input bit poke_busy);
        int            a0, r0, n;
        bit            got;
        logic [AW-1:0] a;
        for (int i = 0; i < cnt; i++) begin
            a = sa + AW'(i);
            exp_q.push_back({a, mem[a]});
        end
        a0 = acc_count;
        r0 = rd_count;
        rdy_mode = mode;
        pulse_start(sa, cnt);
        if (poke_busy && cnt >= 4) pulse_start(sa + AW'(100), 5);
        got = 1'b0;
        n = 0;
        while (!got && n < 400) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
        end
        check_eq("done_seen", got, 1);
        if (got) begin
            check_eq("aborted_clear", aborted, 0);
            check_eq("words_left", exp_q.size(), 0);
            check_eq("words_taken", acc_count - a0, cnt);
            check_eq("ram_reads", rd_count - r0, cnt);
            if (cnt == 0) check_eq("zero_done_latency", n, 1);
            if (mode == 0 && cnt > 0 && acc_count - a0 == cnt) begin
                check_eq("back_to_back", acc_cyc[acc_count-1] - acc_cyc[a0], cnt - 1);
                check_eq("done_latency", cyc - acc_cyc[acc_count-1], 1);
            end
        end
        @(negedge clk);
        check_eq("done_pulse", done, 0);
        check_eq("idle_busy", busy, 0);
        exp_q.delete();
    endtask

    task automatic abort_dump();
        int a0, r0, d0, n;
        for (int i = 0; i < 6; i++) exp_q.push_back({AW'(i), mem[i]});
        a0 = acc_count;
        d0 = done_seen;
        rdy_mode = 0;
        pulse_start('0, 6);
        n = 0;
        while (acc_count - a0 < 2 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("abort_reached_two", acc_count - a0, 2);
        debug    = 1'b0;
        rdy_mode = 3;
        r0 = rd_count;
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_valid", dump_valid, 0);
        check_eq("abort_done", done, 1);
        check_eq("abort_flag", aborted, 1);
        repeat (5) @(negedge clk);
        check_eq("abort_no_reads", rd_count - r0, 0);
        check_eq("abort_one_done", done_seen - d0, 1);
        check_eq("abort_words", acc_count - a0, 2);
        exp_q.delete();
        @(posedge clk); #1;
        debug = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int d0, r0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0001;
        mem[1] = 32'h000F_0130;
        mem[2] = 32'h00AB_0130;
        mem[3] = 32'h0000_1001;
        mem[4] = 32'h0001_0820;
        mem[5] = 32'h0542_1004;

        debug = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        run_dump('0, 6, 0, 1'b0);
        run_dump('0, 6, 1, 1'b0);
        run_dump(16'hFFFE, 3, 0, 1'b0);
        run_dump('0, 0, 0, 1'b0);
        abort_dump();

        // Reset mid-dump: consumer held off so no words are taken before reset.
        rdy_mode = 3;
        pulse_start('0, 6);
        repeat (4) @(posedge clk);
        #1;
        d0 = done_seen;
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("midreset");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("reset_no_done", done_seen - d0, 0);
        run_dump(16'd3, 2, 2, 1'b0);

        // start while debug is low is ignored
        debug = 1'b0;
        d0 = done_seen;
        r0 = rd_count;
        pulse_start(16'd10, 4);
        repeat (6) @(negedge clk);
        check_eq("nodebug_busy", busy, 0);
        check_eq("nodebug_reads", rd_count - r0, 0);
        check_eq("nodebug_done", done_seen - d0, 0);
        @(posedge clk); #1;
        debug = 1'b1;

        for (int k = 0; k < 10; k++) begin
            run_dump(AW'($urandom), $urandom_range(1, 9), $urandom_range(0, 2), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
